// File: rtl/nn_calc_controller.sv
// Fully-connected layer MAC sequencer. Start to done takes NUM_OUTPUTS*(NUM_INPUTS+2) cycles; there is no backpressure because memories answer one cycle after rd_en.
// Define RELU_EN to write negative results as 0 instead of saturating them.
module nn_calc_controller #(
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_OUTPUTS = 10,
    parameter int ACC_WIDTH   = 36,
    parameter int FRAC_BITS   = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start_calc,
    input  logic        clear_data,
    output logic [9:0]  pixel_addr,
    output logic [12:0] weight_addr,
    output logic        rd_en,
    input  logic [7:0]  pixel_in,
    input  logic [15:0] weight_in,
    output logic        result_we,
    output logic [3:0]  result_addr,
    output logic [15:0] result_data,
    output logic        busy,
    output logic        done_calc,
    output logic        overflow
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [9:0] IN_LAST  = 10'(NUM_INPUTS - 1);
    localparam logic [3:0] OUT_LAST = 4'(NUM_OUTPUTS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32'sd32767);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-32'sd32768);

    logic [2:0]                  state;
    logic [9:0]                  in_idx;
    logic [3:0]                  out_idx;
    logic [12:0]                 waddr;
    logic                        rd_q;
    logic                        ovf;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [24:0]          prod;
    logic [15:0]                 sat_val;
    logic                        clamp;

    // Pixel is unsigned, so it gets a zero sign bit before the signed multiply.
    assign prod    = 25'($signed({1'b0, pixel_in})) * 25'($signed(weight_in));
    assign shifted = acc >>> FRAC_BITS;

    always_comb begin
        sat_val = shifted[15:0];
        clamp   = 1'b0;
        if (shifted > SAT_MAX) begin
            sat_val = 16'h7FFF;
            clamp   = 1'b1;
        end
`ifdef RELU_EN
        else if (shifted[ACC_WIDTH-1]) begin
            sat_val = 16'h0000;
        end
`else
        else if (shifted < SAT_MIN) begin
            sat_val = 16'h8000;
            clamp   = 1'b1;
        end
`endif
    end

    assign rd_en       = (state == S_RUN);
    assign pixel_addr  = rd_en ? in_idx : 10'd0;
    assign weight_addr = rd_en ? waddr : 13'd0;
    assign result_we   = (state == S_WRITE) && !clear_data && n_rst;
    assign result_addr = result_we ? out_idx : 4'd0;
    assign result_data = result_we ? sat_val : 16'd0;
    assign busy        = (state == S_RUN) || (state == S_DRAIN) || (state == S_WRITE);
    assign done_calc   = (state == S_DONE);
    assign overflow    = ovf;

    always_ff @(posedge clk) begin
        if (!n_rst || clear_data) begin
            state   <= S_IDLE;
            in_idx  <= 10'd0;
            out_idx <= 4'd0;
            waddr   <= 13'd0;
            rd_q    <= 1'b0;
            acc     <= '0;
            ovf     <= 1'b0;
        end else begin
            // rd_q marks a cycle whose inputs carry data requested one cycle earlier.
            rd_q <= (state == S_RUN);
            if (rd_q)
                acc <= acc + ACC_WIDTH'(prod);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_calc) begin
                        state   <= S_RUN;
                        in_idx  <= 10'd0;
                        out_idx <= 4'd0;
                        waddr   <= 13'd0;
                        acc     <= '0;
                        ovf     <= 1'b0;
                    end
                end
                S_RUN: begin
                    // waddr keeps counting across neurons so it lands on the next row base.
                    waddr <= waddr + 13'd1;
                    if (in_idx == IN_LAST)
                        state <= S_DRAIN;
                    else
                        in_idx <= in_idx + 10'd1;
                end
                S_DRAIN: state <= S_WRITE;
                S_WRITE: begin
                    acc    <= '0;
                    in_idx <= 10'd0;
                    ovf    <= ovf | clamp;
                    if (out_idx == OUT_LAST) begin
                        state <= S_DONE;
                    end else begin
                        out_idx <= out_idx + 4'd1;
                        state   <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_calc_controller.sv
// Bench for nn_calc_controller: a default-size instance with random memories checked against an arithmetic model, plus a 4x2 instance for the small hand-worked case.
module tb_nn_calc_controller;
    localparam int NI = 784;
    localparam int NO = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    logic        n_rst = 1'b0;
    logic        start_calc = 1'b0;
    logic        clear_data = 1'b0;
    logic [9:0]  pixel_addr;
    logic [12:0] weight_addr;
    logic        rd_en;
    logic [7:0]  pixel_in = 8'd0;
    logic [15:0] weight_in = 16'd0;
    logic        result_we;
    logic [3:0]  result_addr;
    logic [15:0] result_data;
    logic        busy, done_calc, overflow;

    nn_calc_controller dut (
        .clk(clk), .n_rst(n_rst), .start_calc(start_calc), .clear_data(clear_data),
        .pixel_addr(pixel_addr), .weight_addr(weight_addr), .rd_en(rd_en),
        .pixel_in(pixel_in), .weight_in(weight_in),
        .result_we(result_we), .result_addr(result_addr), .result_data(result_data),
        .busy(busy), .done_calc(done_calc), .overflow(overflow)
    );

    logic        s_start = 1'b0;
    logic        s_clear = 1'b0;
    logic [9:0]  s_pixel_addr;
    logic [12:0] s_weight_addr;
    logic        s_rd_en;
    logic [7:0]  s_pixel_in = 8'd0;
    logic [15:0] s_weight_in = 16'd0;
    logic        s_result_we;
    logic [3:0]  s_result_addr;
    logic [15:0] s_result_data;
    logic        s_busy, s_done, s_overflow;

    nn_calc_controller #(.NUM_INPUTS(4), .NUM_OUTPUTS(2)) dut_small (
        .clk(clk), .n_rst(n_rst), .start_calc(s_start), .clear_data(s_clear),
        .pixel_addr(s_pixel_addr), .weight_addr(s_weight_addr), .rd_en(s_rd_en),
        .pixel_in(s_pixel_in), .weight_in(s_weight_in),
        .result_we(s_result_we), .result_addr(s_result_addr), .result_data(s_result_data),
        .busy(s_busy), .done_calc(s_done), .overflow(s_overflow)
    );

    logic [7:0]  pmem [NI];
    logic [15:0] wmem [NI*NO];
    logic [7:0]  s_pmem [4];
    logic [15:0] s_wmem [8];

    // Memory models: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            pixel_in  <= pmem[pixel_addr];
            weight_in <= wmem[weight_addr];
        end
        if (s_rd_en) begin
            s_pixel_in  <= s_pmem[s_pixel_addr[1:0]];
            s_weight_in <= s_wmem[s_weight_addr[2:0]];
        end
    end

    int wa_q[$];
    int wd_q[$];
    int s_wa_q[$];
    int s_wd_q[$];
    int exp_wa   = 0;
    int rd_run   = 0;
    int addr_bad = 0;

    always @(negedge clk) begin
        if (result_we) begin
            wa_q.push_back(int'(result_addr));
            wd_q.push_back(int'($signed(result_data)));
        end
        if (s_result_we) begin
            s_wa_q.push_back(int'(s_result_addr));
            s_wd_q.push_back(int'($signed(s_result_data)));
        end
        if (rd_en) begin
            if (int'(weight_addr) != exp_wa || int'(pixel_addr) != exp_wa % NI)
                addr_bad++;
            exp_wa++;
            rd_run++;
        end else if (rd_run != 0) begin
            if (rd_run != NI)
                addr_bad++;
            rd_run = 0;
        end
    end

    // Reference: dot product, floor-divide by 256, then clamp.
    task automatic model(input int o, output longint r, output bit ovf);
        longint s = 0;
        for (int i = 0; i < NI; i++)
            s += longint'(pmem[i]) * longint'($signed(wmem[o*NI + i]));
        r   = s >>> 8;
        ovf = 1'b0;
`ifdef RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > 32767) begin r = 32767; ovf = 1'b1; end
        if (r < -32768) begin r = -32768; ovf = 1'b1; end
    endtask

    task automatic run_full(input string tag, input bit mid_start);
        int     cyc = 0;
        longint r;
        bit     o_ovf;
        bit     any_ovf = 1'b0;
        wa_q.delete();
        wd_q.delete();
        exp_wa   = 0;
        addr_bad = 0;
        start_calc = 1'b1;
        @(negedge clk);
        start_calc = 1'b0;
        while (!done_calc && cyc < 9000) begin
            @(negedge clk);
            cyc++;
            start_calc = (mid_start && cyc == 300);
        end
        start_calc = 1'b0;
        check({tag, "_done"}, done_calc, 1);
        check({tag, "_latency"}, cyc, NI*NO + 2*NO);
        check({tag, "_nwrites"}, wa_q.size(), NO);
        check({tag, "_addrseq"}, addr_bad, 0);
        check({tag, "_busy"}, busy, 0);
        for (int o = 0; o < NO; o++) begin
            model(o, r, o_ovf);
            any_ovf |= o_ovf;
            if (o < wa_q.size()) begin
                check({tag, "_waddr"}, wa_q[o], o);
                check({tag, "_wdata"}, wd_q[o], r);
            end
        end
        check({tag, "_overflow"}, overflow, any_ovf);
    endtask

    initial begin
        int cyc;
        int n_before;

        // Reset held, then a start pulse while still in reset.
        repeat (2) @(negedge clk);
        check("reset_outs", {rd_en, busy, done_calc, overflow, result_we, pixel_addr,
                             weight_addr, result_addr, result_data}, 0);
        start_calc = 1'b1;
        s_start    = 1'b1;
        @(negedge clk);
        check("reset_start_busy", {busy, rd_en, s_busy, s_rd_en}, 0);
        start_calc = 1'b0;
        s_start    = 1'b0;
        n_rst      = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {busy, done_calc, s_busy, s_done}, 0);

        // Small 4x2 case: row0 weight 1.0, row1 weight -1.0.
        for (int i = 0; i < 4; i++) begin
            s_pmem[i]     = 8'(i + 1);
            s_wmem[i]     = 16'h0100;
            s_wmem[i + 4] = 16'hFF00;
        end
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        cyc = 0;
        while (!s_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("small_latency", cyc, 12);
        check("small_nwrites", s_wa_q.size(), 2);
        if (s_wa_q.size() == 2) begin
            check("small_addr0", s_wa_q[0], 0);
            check("small_data0", s_wd_q[0], 10);
            check("small_addr1", s_wa_q[1], 1);
`ifdef RELU_EN
            check("small_data1", s_wd_q[1], 0);
`else
            check("small_data1", s_wd_q[1], -10);
`endif
        end
        check("small_overflow", s_overflow, 0);

        // Random pixels with small weights: results stay in range.
        for (int i = 0; i < NI; i++) pmem[i] = 8'($urandom);
        for (int i = 0; i < NI*NO; i++) wmem[i] = 16'(int'($urandom_range(511)) - 256);
        run_full("rand_small", 1'b0);

        // Full-range weights, with a stray start pulse mid-run.
        for (int i = 0; i < NI*NO; i++) wmem[i] = 16'($urandom);
        run_full("rand_full_midstart", 1'b1);

        // Positive saturation.
        for (int i = 0; i < NI; i++) pmem[i] = 8'hFF;
        for (int i = 0; i < NI*NO; i++) wmem[i] = 16'h7FFF;
        run_full("sat_pos", 1'b0);
        if (wd_q.size() > 0) check("sat_pos_const", wd_q[0], 32767);
        check("sat_pos_ovf_const", overflow, 1);

        // Zero weights clear the sticky overflow on a new start.
        for (int i = 0; i < NI*NO; i++) wmem[i] = 16'h0000;
        run_full("zero", 1'b0);

        // Negative extreme.
        for (int i = 0; i < NI*NO; i++) wmem[i] = 16'h8000;
        run_full("sat_neg", 1'b0);

        // start and clear together from DONE: clear wins.
        start_calc = 1'b1;
        clear_data = 1'b1;
        @(negedge clk);
        start_calc = 1'b0;
        clear_data = 1'b0;
        check("clr_start_state", {busy, done_calc, overflow}, 0);

        // Abort after 100 cycles of a run.
        for (int i = 0; i < NI; i++) pmem[i] = 8'($urandom);
        for (int i = 0; i < NI*NO; i++) wmem[i] = 16'(int'($urandom_range(1023)) - 512);
        wa_q.delete();
        wd_q.delete();
        start_calc = 1'b1;
        @(negedge clk);
        start_calc = 1'b0;
        repeat (99) @(negedge clk);
        check("abort_busy_before", busy, 1);
        clear_data = 1'b1;
        @(negedge clk);
        clear_data = 1'b0;
        check("abort_busy_after", busy, 0);
        n_before = wa_q.size();
        repeat (2000) @(negedge clk);
        check("abort_no_writes", wa_q.size() - n_before, 0);
        check("abort_idle", {busy, done_calc, rd_en}, 0);
        run_full("after_abort", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
